// File: rtl/alu_sequencer.sv
// alu_sequencer: command-driven sequencer that owns an NREG x DW register file
// and drives an external ALU. It accepts one command at a time, issues ALU ops
// (cmd_op[3]==0) or performs register ops (cmd_op[3]==1), writes the result
// back and returns a one-cycle response.
//
// Ports:
//   CLK, RST                      clock; synchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op/rd/ra/rb/imm           command fields, captured at acceptance
//   alu_en/opcode/a/b             ALU issue strobe and operands
//   alu_result/alu_cf             ALU result and carry, valid ALU_LAT after issue
//   rsp_valid/data/cf/err         one-cycle completion response
//   cf_flag                       architectural carry flag
//   busy                          sequencer not idle
module alu_sequencer #(
  parameter int DW      = 16,
  parameter int NREG    = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_op,
  input  logic [$clog2(NREG)-1:0] cmd_rd,
  input  logic [$clog2(NREG)-1:0] cmd_ra,
  input  logic [$clog2(NREG)-1:0] cmd_rb,
  input  logic [DW-1:0]           cmd_imm,
  output logic                    alu_en,
  output logic [3:0]              alu_opcode,
  output logic [DW-1:0]           alu_a,
  output logic [DW-1:0]           alu_b,
  input  logic [DW-1:0]           alu_result,
  input  logic                    alu_cf,
  output logic                    rsp_valid,
  output logic [DW-1:0]           rsp_data,
  output logic                    rsp_cf,
  output logic                    rsp_err,
  output logic                    cf_flag,
  output logic                    busy
);
  localparam int AW = $clog2(NREG);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EXEC, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [NREG-1:0][DW-1:0]  rf_q;
  logic [3:0]               op_q;
  logic [AW-1:0]            rd_q, ra_q;
  logic [DW-1:0]            imm_q;
  logic                     cf_q;
  logic [DW-1:0]            alu_a_q, alu_b_q;
  logic [3:0]               alu_op_q;
  logic [DW-1:0]            rsp_data_q, rsp_data_d;
  logic                     rsp_err_q, rsp_err_d;

  logic                     accept;
  logic                     rf_we;
  logic [DW-1:0]            rf_wdata;
  logic                     cf_we, cf_wdata;

  assign cmd_ready  = (state_q == S_IDLE) & RST;
  assign accept     = cmd_valid & cmd_ready;
  assign alu_en     = (state_q == S_ISSUE);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign rsp_valid  = (state_q == S_DONE);
  assign rsp_cf     = rsp_valid & cf_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign cf_flag    = cf_q;
  assign busy       = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rf_we      = 1'b0;
    rf_wdata   = '0;
    cf_we      = 1'b0;
    cf_wdata   = 1'b0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d   = cmd_op[3] ? S_EXEC : S_ISSUE;
        rsp_err_d = 1'b0;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CW'(ALU_LAT - 1);
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rf_we      = 1'b1;
          rf_wdata   = alu_result;
          cf_we      = 1'b1;
          cf_wdata   = alu_cf;
          rsp_data_d = alu_result;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
        case (op_q[2:0])
          3'b000: begin rf_we = 1'b1; rf_wdata = imm_q;       rsp_data_d = imm_q;       end
          3'b001: begin rf_we = 1'b1; rf_wdata = rf_q[ra_q];  rsp_data_d = rf_q[ra_q];  end
          3'b010: rsp_data_d = rf_q[ra_q];
          3'b011: begin cf_we = 1'b1; cf_wdata = 1'b0; rsp_data_d = '0; end
          default: begin rsp_data_d = '0; rsp_err_d = 1'b1; end
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rf_q       <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      ra_q       <= '0;
      imm_q      <= '0;
      cf_q       <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      if (accept) begin
        op_q  <= cmd_op;
        rd_q  <= cmd_rd;
        ra_q  <= cmd_ra;
        imm_q <= cmd_imm;
        // No write can be pending while idle, so sampling the operands here
        // equals reading them in ISSUE; the registers then hold through WAIT.
        if (!cmd_op[3]) begin
          alu_a_q  <= rf_q[cmd_ra];
          alu_b_q  <= rf_q[cmd_rb];
          alu_op_q <= cmd_op;
        end
      end
      if (rf_we) rf_q[rd_q] <= rf_wdata;
      if (cf_we) cf_q <= cf_wdata;
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: one instance with ALU_LAT=1 and one with
// ALU_LAT=4, each fed by a simple ADD model of the ALU.
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst1, rst4, v1, v4;
  logic [3:0]  c_op;
  logic [2:0]  c_rd, c_ra, c_rb;
  logic [15:0] c_imm;

  logic        ready1, en1, rv1, rcf1, rerr1, cff1, busy1, acf1;
  logic [3:0]  aop1;
  logic [15:0] a1, b1, ares1, rd1;
  logic        ready4, en4, rv4, rcf4, rerr4, cff4, busy4, acf4;
  logic [3:0]  aop4;
  logic [15:0] a4, b4, ares4, rd4;

  always #5 clk = ~clk;

  // ALU model: ADD with carry out
  assign {acf1, ares1} = {1'b0, a1} + {1'b0, b1};
  assign {acf4, ares4} = {1'b0, a4} + {1'b0, b4};

  alu_sequencer #(.DW(16), .NREG(8), .ALU_LAT(1)) u_dut1 (
    .CLK(clk), .RST(rst1), .cmd_valid(v1), .cmd_ready(ready1), .cmd_op(c_op),
    .cmd_rd(c_rd), .cmd_ra(c_ra), .cmd_rb(c_rb), .cmd_imm(c_imm),
    .alu_en(en1), .alu_opcode(aop1), .alu_a(a1), .alu_b(b1),
    .alu_result(ares1), .alu_cf(acf1), .rsp_valid(rv1), .rsp_data(rd1),
    .rsp_cf(rcf1), .rsp_err(rerr1), .cf_flag(cff1), .busy(busy1));

  alu_sequencer #(.DW(16), .NREG(8), .ALU_LAT(4)) u_dut4 (
    .CLK(clk), .RST(rst4), .cmd_valid(v4), .cmd_ready(ready4), .cmd_op(c_op),
    .cmd_rd(c_rd), .cmd_ra(c_ra), .cmd_rb(c_rb), .cmd_imm(c_imm),
    .alu_en(en4), .alu_opcode(aop4), .alu_a(a4), .alu_b(b4),
    .alu_result(ares4), .alu_cf(acf4), .rsp_valid(rv4), .rsp_data(rd4),
    .rsp_cf(rcf4), .rsp_err(rerr4), .cf_flag(cff4), .busy(busy4));

  int          sel = 1;
  logic        s_ready, s_en, s_rv, s_cf, s_err;
  logic [15:0] s_a, s_b, s_data;
  always_comb begin
    s_ready = ready1; s_en = en1; s_rv = rv1; s_cf = rcf1; s_err = rerr1;
    s_a = a1; s_b = b1; s_data = rd1;
    if (sel == 4) begin
      s_ready = ready4; s_en = en4; s_rv = rv4; s_cf = rcf4; s_err = rerr4;
      s_a = a4; s_b = b4; s_data = rd4;
    end
  end

  int n_chk = 0, n_err = 0;
  logic [15:0] r_data, r_a, r_b;
  logic        r_cf, r_err;
  int          r_lat, r_low, r_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command on the selected instance and record its response,
  // latency (cycles after acceptance), ready-low cycles and alu_en pulses.
  task automatic run_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic [15:0] imm);
    bit ok;
    r_data = '0; r_cf = 1'b0; r_err = 1'b0; r_lat = 0; r_low = 0; r_en = 0; r_a = '0; r_b = '0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin chk("ready_wait", 0, 1); return; end
    c_op = op; c_rd = rd; c_ra = ra; c_rb = rb; c_imm = imm;
    if (sel == 4) v4 = 1'b1; else v1 = 1'b1;
    @(posedge clk);
    #1 v1 = 1'b0; v4 = 1'b0;
    c_imm = 16'hDEAD; c_ra = 3'd7; c_rb = 3'd7;
    ok = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (s_en) begin r_en++; r_a = s_a; r_b = s_b; end
      if (s_rv) begin r_data = s_data; r_cf = s_cf; r_err = s_err; r_lat = k; end
      if (s_ready) begin ok = 1'b1; break; end
      r_low++;
    end
    if (!ok) chk("done_wait", 0, 1);
  endtask

  initial begin
    bit seen;
    rst1 = 1'b0; rst4 = 1'b0; v1 = 1'b0; v4 = 1'b0;
    c_op = '0; c_rd = '0; c_ra = '0; c_rb = '0; c_imm = '0;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_ready", ready1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_rsp_valid", rv1, 0);
    chk("rst_rsp_data", rd1, 0);
    chk("rst_alu_en", en1, 0);
    chk("rst_alu_a", a1, 0);
    chk("rst_cf_flag", cff1, 0);
    rst1 = 1'b1; rst4 = 1'b1;
    @(negedge clk);
    chk("rst_ready_after", ready1, 1);
    for (int r = 0; r < 8; r++) begin
      run_cmd(4'b1010, 3'd0, 3'(r), 3'd0, 16'h0);
      chk("rst_rd_data", r_data, 0);
      chk("rst_rd_cf", r_cf, 0);
    end
    chk("rd_latency", r_lat, 2);
    chk("rd_ready_low", r_low, 2);

    // ALU add, ALU_LAT=1
    run_cmd(4'b1000, 3'd1, 3'd0, 3'd0, 16'h0005);
    chk("ldi_r1", r_data, 16'h0005);
    run_cmd(4'b1000, 3'd2, 3'd0, 3'd0, 16'h0003);
    run_cmd(4'b0000, 3'd3, 3'd1, 3'd2, 16'h0);
    chk("add_en_pulses", r_en, 1);
    chk("add_a", r_a, 16'h0005);
    chk("add_b", r_b, 16'h0003);
    chk("add_latency", r_lat, 3);
    chk("add_ready_low", r_low, 3);
    chk("add_data", r_data, 16'h0008);
    chk("add_cf", r_cf, 0);
    chk("add_err", r_err, 0);
    run_cmd(4'b1010, 3'd0, 3'd3, 3'd0, 16'h0);
    chk("rd_r3", r_data, 16'h0008);

    // Carry, then CLRF
    run_cmd(4'b1000, 3'd1, 3'd0, 3'd0, 16'hFFFF);
    run_cmd(4'b1000, 3'd2, 3'd0, 3'd0, 16'h0001);
    run_cmd(4'b0000, 3'd4, 3'd1, 3'd2, 16'h0);
    chk("carry_data", r_data, 16'h0000);
    chk("carry_cf", r_cf, 1);
    chk("carry_flag", cff1, 1);
    run_cmd(4'b1010, 3'd0, 3'd1, 3'd0, 16'h0);
    chk("rd_keeps_cf", r_cf, 1);
    run_cmd(4'b1011, 3'd0, 3'd0, 3'd0, 16'h0);
    chk("clrf_cf", r_cf, 0);
    chk("clrf_flag", cff1, 0);
    chk("clrf_data", r_data, 0);

    // Hazard rd=ra=rb, MOV
    run_cmd(4'b1000, 3'd5, 3'd0, 3'd0, 16'h1234);
    run_cmd(4'b0000, 3'd5, 3'd5, 3'd5, 16'h0);
    chk("hazard_data", r_data, 16'h2468);
    run_cmd(4'b1001, 3'd6, 3'd5, 3'd0, 16'h0);
    chk("mov_data", r_data, 16'h2468);
    run_cmd(4'b1010, 3'd0, 3'd6, 3'd0, 16'h0);
    chk("rd_r6", r_data, 16'h2468);

    // Illegal op leaves registers alone
    run_cmd(4'b1100, 3'd1, 3'd5, 3'd5, 16'h5555);
    chk("illegal_err", r_err, 1);
    chk("illegal_data", r_data, 0);
    chk("illegal_latency", r_lat, 2);
    run_cmd(4'b1010, 3'd0, 3'd1, 3'd0, 16'h0);
    chk("ill_r1", r_data, 16'hFFFF);
    chk("ill_err_clears", r_err, 0);
    run_cmd(4'b1010, 3'd0, 3'd2, 3'd0, 16'h0);
    chk("ill_r2", r_data, 16'h0001);
    run_cmd(4'b1010, 3'd0, 3'd3, 3'd0, 16'h0);
    chk("ill_r3", r_data, 16'h0008);
    run_cmd(4'b1010, 3'd0, 3'd5, 3'd0, 16'h0);
    chk("ill_r5", r_data, 16'h2468);

    // ALU_LAT = 4
    sel = 4;
    run_cmd(4'b1000, 3'd1, 3'd0, 3'd0, 16'h0005);
    run_cmd(4'b1000, 3'd2, 3'd0, 3'd0, 16'h0003);
    run_cmd(4'b0000, 3'd3, 3'd1, 3'd2, 16'h0);
    chk("lat4_latency", r_lat, 6);
    chk("lat4_ready_low", r_low, 6);
    chk("lat4_en_pulses", r_en, 1);
    chk("lat4_data", r_data, 16'h0008);

    // Reset in the second WAIT cycle
    seen = 1'b0;
    @(negedge clk);
    c_op = 4'b0000; c_rd = 3'd7; c_ra = 3'd1; c_rb = 3'd2;
    v4 = 1'b1;
    @(posedge clk);
    #1 v4 = 1'b0;
    @(negedge clk); seen |= rv4;          // ISSUE
    @(negedge clk); seen |= rv4;          // WAIT 1
    @(negedge clk); seen |= rv4;          // WAIT 2
    rst4 = 1'b0;
    @(negedge clk); seen |= rv4;
    chk("midrst_busy", busy4, 0);
    chk("midrst_ready", ready4, 0);
    rst4 = 1'b1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); seen |= rv4; end
    chk("midrst_no_rsp", seen, 0);
    run_cmd(4'b1010, 3'd0, 3'd7, 3'd0, 16'h0);
    chk("midrst_r7", r_data, 0);
    run_cmd(4'b1000, 3'd1, 3'd0, 3'd0, 16'h0100);
    chk("post_ldi", r_data, 16'h0100);
    run_cmd(4'b1000, 3'd2, 3'd0, 3'd0, 16'h0023);
    run_cmd(4'b0000, 3'd7, 3'd1, 3'd2, 16'h0);
    chk("post_add_data", r_data, 16'h0123);
    chk("post_add_latency", r_lat, 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
